// File: rtl/dm_responder_if.sv
// Load/store bus between the CPU datapath and the data-memory responder.
// The master drives one request; the slave answers with a one-cycle ready pulse
// carrying read data and the misalignment flag.
interface dm_responder_if;
  logic        req;
  logic        we;
  logic        lb;
  logic        sb;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        busy;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, lb, sb, addr, wdata,
    input  ready, busy, rdata, err
  );

  modport slave (
    input  req, we, lb, sb, addr, wdata,
    output ready, busy, rdata, err
  );
endinterface

// File: rtl/dm_responder.sv
// Multicycle data-memory responder: accepts one request per handshake, waits
// WAIT_CYC cycles, then performs a word access, a sign-extended byte load, or
// (with DM_SB_EN defined) a byte store, and returns registered read data.
// Optional feature macro: DM_SB_EN enables byte stores on the sb input.
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  dm_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_lb;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_busy;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic              w_sbEn;
  logic              w_byteRead;
  logic              w_misaligned;
  logic              w_access;

  assign w_idx      = r_addr[ADDR_W+1:2];
  assign w_lane     = r_addr[1:0];
  assign w_word     = r_mem[w_idx];
  assign w_byte     = w_word[{w_lane, 3'b000} +: 8];
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_byteRead = r_lb && !r_we;

`ifdef DM_SB_EN
  logic r_sb;
  assign w_sbEn = r_we && r_sb;

  // Capture the store-byte qualifier alongside the rest of the request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_sb <= 1'b0;
    else if (r_state == S_IDLE && bus.req)
      r_sb <= bus.sb;
  end
`else
  logic w_unused_sb;
  assign w_sbEn      = 1'b0;
  assign w_unused_sb = bus.sb;
`endif

  // Only word accesses care about alignment; byte loads and byte stores pick a lane.
  assign w_misaligned = !w_byteRead && !w_sbEn && (w_lane != 2'b00);

  // Request FSM: capture on accept, count down wait states, access, then pulse ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_lb    <= 1'b0;
      r_addr  <= 12'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_lb    <= bus.lb;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= 4'(WAIT_CYC);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_ready <= 1'b1;
            r_err   <= w_misaligned;
            if (r_we || w_misaligned)
              r_rdata <= 32'd0;
            else if (w_byteRead)
              r_rdata <= {{24{w_byte[7]}}, w_byte};
            else
              r_rdata <= w_word;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage update on the access edge; the array is deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (w_access && r_we && !w_misaligned) begin
      if (w_sbEn)
        r_mem[w_idx][{w_lane, 3'b000} +: 8] <= r_wdata[7:0];
      else
        r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a timestamp-based reference model is
// compared against the DUT outputs on every falling edge, and directed accesses
// carry hand-computed expected values.
module tb_dm_responder;

  localparam int ADDR_W   = 10;
  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 1 << ADDR_W;
`ifdef DM_SB_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  dm_responder_if bus();

  int nChecks = 0;
  int nFail   = 0;
  bit chkEn   = 1'b0;

  dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one comparison and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, exp);
    end
  endtask

  // Reference model: memory as a plain word array, timing as edge timestamps.
  logic [31:0] mMem [DEPTH];
  int          edgeCnt    = 0;
  int          accessEdge = 0;
  bit          pending;
  logic        cWe, cLb, cSb;
  logic [11:0] cAddr;
  logic [31:0] cWdata;
  logic        mReady, mBusy, mErr;
  logic [31:0] mRdata;

  function automatic bit modelErr(input logic we, input logic lb, input logic sb, input logic [11:0] a);
    bit byteOp;
    byteOp = (lb && !we) || (SB_EN && we && sb);
    return !byteOp && (a % 4 != 0);
  endfunction

  function automatic logic [31:0] modelRdata(input logic [31:0] word, input logic we, input logic lb,
                                             input logic sb, input logic [11:0] a);
    int unsigned b;
    if (we || modelErr(we, lb, sb, a)) return 32'd0;
    if (!lb) return word;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    if (b >= 128) return 32'(b) | 32'hFFFF_FF00;
    return 32'(b);
  endfunction

  function automatic logic [31:0] modelNewWord(input logic [31:0] word, input logic sb,
                                               input logic [11:0] a, input logic [31:0] wd);
    int unsigned sh;
    if (!(SB_EN && sb)) return wd;
    sh = 8 * (a % 4);
    return (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
  endfunction

  // Model update: accept when free, act WAIT_CYC+1 edges later, free up one edge after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      mReady  <= 1'b0;
      mBusy   <= 1'b0;
      mErr    <= 1'b0;
      mRdata  <= 32'd0;
    end else begin
      edgeCnt <= edgeCnt + 1;
      if (pending && edgeCnt == accessEdge + 1) begin
        pending <= 1'b0;
        mReady  <= 1'b0;
        mBusy   <= 1'b0;
        mErr    <= 1'b0;
      end else if (pending && edgeCnt == accessEdge) begin
        mReady <= 1'b1;
        mErr   <= modelErr(cWe, cLb, cSb, cAddr);
        mRdata <= modelRdata(mMem[(cAddr >> 2) % DEPTH], cWe, cLb, cSb, cAddr);
        if (cWe && !modelErr(cWe, cLb, cSb, cAddr))
          mMem[(cAddr >> 2) % DEPTH] <= modelNewWord(mMem[(cAddr >> 2) % DEPTH], cSb, cAddr, cWdata);
      end else if (!pending && bus.req) begin
        pending    <= 1'b1;
        mBusy      <= 1'b1;
        accessEdge <= edgeCnt + WAIT_CYC + 1;
        cWe        <= bus.we;
        cLb        <= bus.lb;
        cSb        <= bus.sb;
        cAddr      <= bus.addr;
        cWdata     <= bus.wdata;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("ready", 32'(bus.ready), 32'(mReady));
      checkOutput("busy",  32'(bus.busy),  32'(mBusy));
      checkOutput("err",   32'(bus.err),   32'(mErr));
      checkOutput("rdata", bus.rdata,      mRdata);
    end
  end

  // One complete handshake; returns the completion values and accept-to-ready latency.
  task automatic applyStimulus(input logic we, input logic lb, input logic sb, input logic [11:0] a,
                               input logic [31:0] wd, output logic [31:0] rd, output logic er,
                               output int lat);
    bit found;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = we; bus.lb = lb; bus.sb = sb; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = ~we; bus.lb = ~lb; bus.sb = ~sb; bus.addr = ~a; bus.wdata = ~wd;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!found) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL ready_timeout: got no ready, expected ready within 50 cycles");
    end
    rd = bus.rdata;
    er = bus.err;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;

    bus.req = 1'b0; bus.we = 1'b0; bus.lb = 1'b0; bus.sb = 1'b0;
    bus.addr = 12'd0; bus.wdata = 32'd0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(bus.ready), 32'd0);
    checkOutput("reset_busy",  32'(bus.busy),  32'd0);
    checkOutput("reset_err",   32'(bus.err),   32'd0);
    checkOutput("reset_rdata", bus.rdata,      32'd0);
    chkEn = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] reset abort of an in-flight write");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h020, 32'h0BAD_F00D, rd, er, lat);
    checkOutput("seed_err", 32'(er), 32'd0);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.lb = 1'b0; bus.sb = 1'b0;
    bus.addr = 12'h020; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 bus.req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 32'(bus.ready), 32'd0);
    checkOutput("abort_busy",  32'(bus.busy),  32'd0);
    checkOutput("abort_err",   32'(bus.err),   32'd0);
    checkOutput("abort_rdata", bus.rdata,      32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h020, 32'd0, rd, er, lat);
    checkOutput("abort_keep", rd, 32'h0BAD_F00D);

    $display("[TB] word write/read latency");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h010, 32'h1234_5678, rd, er, lat);
    checkOutput("wr_lat",   32'(lat), 32'd3);
    checkOutput("wr_rdata", rd,       32'd0);
    checkOutput("wr_err",   32'(er),  32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'd0, rd, er, lat);
    checkOutput("rd_lat",   32'(lat), 32'd3);
    checkOutput("rd_rdata", rd,       32'h1234_5678);
    checkOutput("rd_err",   32'(er),  32'd0);

    $display("[TB] byte loads");
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h013, 32'd0, rd, er, lat);
    checkOutput("lb_lane3", rd, 32'h0000_0012);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h011, 32'd0, rd, er, lat);
    checkOutput("lb_lane1", rd, 32'h0000_0056);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h014, 32'h0000_0080, rd, er, lat);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h014, 32'd0, rd, er, lat);
    checkOutput("lb_sext", rd, 32'hFFFF_FF80);
    checkOutput("lb_err",  32'(er), 32'd0);

    $display("[TB] misaligned word accesses");
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h012, 32'd0, rd, er, lat);
    checkOutput("mis_rd_err",   32'(er), 32'd1);
    checkOutput("mis_rd_rdata", rd,      32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h012, 32'hCAFE_F00D, rd, er, lat);
    checkOutput("mis_wr_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'd0, rd, er, lat);
    checkOutput("mis_wr_keep", rd, 32'h1234_5678);

    $display("[TB] lb with write is a word write");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h018, 32'h0000_0155, rd, er, lat);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h018, 32'd0, rd, er, lat);
    checkOutput("lbwe_word", rd, 32'h0000_0155);

    $display("[TB] store byte");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h011, 32'h0000_00AB, rd, er, lat);
    checkOutput("sb_err", 32'(er), SB_EN ? 32'd0 : 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'd0, rd, er, lat);
    checkOutput("sb_word", rd, SB_EN ? 32'h1234_AB78 : 32'h1234_5678);

    $display("[TB] request held high");
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.lb = 1'b0; bus.sb = 1'b0; bus.addr = 12'h020;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    bus.req = 1'b0;
    checkOutput("held_pulses", 32'(pulses), 32'd4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("held_idle_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
